// File: rtl/lidar_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lidar_pkg
// Brief    : Shared point type and stream FSM encoding for the LiDAR path.
// Revision : 1.0 - initial release
// ============================================================================
package lidar_pkg;

    localparam int COORD_W = 8;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } point_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } tx_state_t;

endpackage : lidar_pkg
`default_nettype wire

// File: rtl/point_buf.sv
`default_nettype none
// ============================================================================
// Module   : point_buf
// Brief    : DEPTH x 24-bit point register array, one write port and one
//            combinational read port.
// Revision : 1.0 - initial release
// ============================================================================
module point_buf
    import lidar_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  point_t        i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output point_t        o_rd_data
);

    // Contents need no reset: the owner's fill count gates what is readable.
    point_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : point_buf
`default_nettype wire

// File: rtl/point_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : point_stream_tx
// Brief    : Buffers host-loaded points and replays them on a valid/last
//            stream with an optional fixed inter-beat gap.
// Revision : 1.0 - initial release
// ============================================================================
module point_stream_tx
    import lidar_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int GAP   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [COORD_W-1:0] wr_z,
    input  logic               clear,
    input  logic               start,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] z,
    output logic               valid,
    output logic               last,
    output logic               busy,
    output logic               done,
    output logic [AW:0]        count,
    output logic               ovf
);

    localparam logic [3:0]  c_gap_reload = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [AW:0] c_cnt_one    = (AW + 1)'(1);

    tx_state_t   r_state, w_state_nxt;
    logic [AW:0] r_rd_ptr, w_rd_ptr_nxt;
    logic [3:0]  r_gap_cnt, w_gap_nxt;
    point_t      r_pt, w_pt_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_last, w_last_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic [AW:0] r_count;
    logic        r_ovf;

    logic        w_full, w_clear_ok, w_start_ok, w_wr_ok, w_ovf_set;
    logic        w_first, w_beat;
    logic [AW:0] w_ptr;
    point_t      w_wr_pt, w_rd_pt;

    assign w_full     = r_count[AW];
    assign w_clear_ok = clear & ~r_busy;
    assign w_start_ok = start & (r_state == IDLE) & ~w_clear_ok;
    assign w_wr_ok    = wr_en & ~r_busy & ~w_full & ~clear & ~w_start_ok;
    assign w_ovf_set  = wr_en & ~r_busy & w_full & ~clear;

    // The first beat is issued straight out of IDLE so it appears the cycle
    // after start; later beats come from SEND with the live read pointer.
    assign w_first = w_start_ok & (r_count != '0);
    assign w_beat  = w_first | (r_state == SEND);
    assign w_ptr   = w_first ? '0 : r_rd_ptr;
    assign w_wr_pt = '{x: wr_x, y: wr_y, z: wr_z};

    point_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (r_count[AW-1:0]),
        .i_wr_data (w_wr_pt),
        .i_rd_addr (w_ptr[AW-1:0]),
        .o_rd_data (w_rd_pt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rd_ptr  <= '0;
            r_gap_cnt <= '0;
            r_pt      <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_pt      <= w_pt_nxt;
            r_valid   <= w_valid_nxt;
            r_last    <= w_last_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            if (w_clear_ok) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_wr_ok) begin
                    r_count <= r_count + c_cnt_one;
                end
                if (w_ovf_set) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rd_ptr_nxt = r_rd_ptr;
        w_gap_nxt    = r_gap_cnt;
        w_pt_nxt     = r_pt;
        w_valid_nxt  = 1'b0;
        w_last_nxt   = 1'b0;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;

        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_done_nxt = 1'b0;
                    if (w_first) begin
                        w_busy_nxt = 1'b1;
                    end else begin
                        w_state_nxt = FIN;
                    end
                end
            end
            WAIT: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = SEND;
                end else begin
                    w_gap_nxt = r_gap_cnt - 4'd1;
                end
            end
            FIN: begin
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: ;
        endcase

        if (w_beat) begin
            w_pt_nxt     = w_rd_pt;
            w_valid_nxt  = 1'b1;
            w_last_nxt   = (w_ptr == r_count - c_cnt_one);
            w_rd_ptr_nxt = w_ptr + c_cnt_one;
            if (w_last_nxt) begin
                w_state_nxt = FIN;
            end else if (GAP > 0) begin
                w_state_nxt = WAIT;
                w_gap_nxt   = c_gap_reload;
            end else begin
                w_state_nxt = SEND;
            end
        end

        if (w_clear_ok) begin
            w_done_nxt = 1'b0;
        end
    end

    assign x     = r_pt.x;
    assign y     = r_pt.y;
    assign z     = r_pt.z;
    assign valid = r_valid;
    assign last  = r_last;
    assign busy  = r_busy;
    assign done  = r_done;
    assign count = r_count;
    assign ovf   = r_ovf;

endmodule : point_stream_tx
`default_nettype wire

// File: tb/tb_point_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_point_stream_tx
// Brief    : Directed self-checking bench for point_stream_tx (GAP 0 and 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_point_stream_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: GAP = 0, instance B: GAP = 2
    logic       a_rst_n, a_wr_en, a_clear, a_start;
    logic [7:0] a_wr_x, a_wr_y, a_wr_z, a_x, a_y, a_z;
    logic       a_valid, a_last, a_busy, a_done, a_ovf;
    logic [6:0] a_count;

    logic       b_rst_n, b_wr_en, b_clear, b_start;
    logic [7:0] b_wr_x, b_wr_y, b_wr_z, b_x, b_y, b_z;
    logic       b_valid, b_last, b_busy, b_done, b_ovf;
    logic [6:0] b_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] px [3];
    logic [7:0] py [3];
    logic [7:0] pz [3];

    point_stream_tx #(.DEPTH(64), .AW(6), .GAP(0)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .wr_en(a_wr_en),
        .wr_x(a_wr_x), .wr_y(a_wr_y), .wr_z(a_wr_z),
        .clear(a_clear), .start(a_start),
        .x(a_x), .y(a_y), .z(a_z), .valid(a_valid), .last(a_last),
        .busy(a_busy), .done(a_done), .count(a_count), .ovf(a_ovf)
    );

    point_stream_tx #(.DEPTH(64), .AW(6), .GAP(2)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .wr_en(b_wr_en),
        .wr_x(b_wr_x), .wr_y(b_wr_y), .wr_z(b_wr_z),
        .clear(b_clear), .start(b_start),
        .x(b_x), .y(b_y), .z(b_z), .valid(b_valid), .last(b_last),
        .busy(b_busy), .done(b_done), .count(b_count), .ovf(b_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] vx, input logic [7:0] vy, input logic [7:0] vz);
        a_wr_en = 1'b1; a_wr_x = vx; a_wr_y = vy; a_wr_z = vz;
        tick();
        a_wr_en = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] vx, input logic [7:0] vy, input logic [7:0] vz);
        b_wr_en = 1'b1; b_wr_x = vx; b_wr_y = vy; b_wr_z = vz;
        tick();
        b_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        tick(); tick();
        n_tests++;
        if ({a_valid, a_last, a_busy, a_done, a_ovf} !== 5'b0 || a_count !== 7'd0
            || {a_x, a_y, a_z} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_a: got v=%b l=%b b=%b d=%b o=%b cnt=%0d xyz=%h, want all 0",
                     a_valid, a_last, a_busy, a_done, a_ovf, a_count, {a_x, a_y, a_z});
        end
        n_tests++;
        if ({b_valid, b_last, b_busy, b_done, b_ovf} !== 5'b0 || b_count !== 7'd0
            || {b_x, b_y, b_z} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_b: got v=%b l=%b b=%b d=%b o=%b cnt=%0d xyz=%h, want all 0",
                     b_valid, b_last, b_busy, b_done, b_ovf, b_count, {b_x, b_y, b_z});
        end
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream_gap0();
        for (int i = 0; i < 3; i++) load_a(px[i], py[i], pz[i]);
        n_tests++;
        if (a_count !== 7'd3) begin
            n_fail++;
            $display("FAIL load_count: got %0d, want 3", a_count);
        end
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (a_valid !== 1'b1 || a_last !== (k == 2) || a_busy !== 1'b1 || a_done !== 1'b0
                || {a_x, a_y, a_z} !== {px[k], py[k], pz[k]}) begin
                n_fail++;
                $display("FAIL gap0_beat%0d: got v=%b l=%b b=%b d=%b xyz=%h, want v=1 l=%b b=1 d=0 xyz=%h",
                         k, a_valid, a_last, a_busy, a_done, {a_x, a_y, a_z},
                         (k == 2), {px[k], py[k], pz[k]});
            end
            tick();
        end
        n_tests++;
        if (a_valid !== 1'b0 || a_last !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b1) begin
            n_fail++;
            $display("FAIL gap0_done: got v=%b l=%b b=%b d=%b, want v=0 l=0 b=0 d=1",
                     a_valid, a_last, a_busy, a_done);
        end
    endtask

    task automatic test_stream_gap2();
        logic exp_v;
        for (int i = 0; i < 3; i++) load_b(px[i], py[i], pz[i]);
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_v = (k % 3 == 0) && (k < 7);
            n_tests++;
            if (b_valid !== exp_v || b_done !== (k == 7) || b_busy !== (k < 7)) begin
                n_fail++;
                $display("FAIL gap2_cyc%0d: got v=%b d=%b b=%b, want v=%b d=%b b=%b",
                         k, b_valid, b_done, b_busy, exp_v, (k == 7), (k < 7));
            end
            if (exp_v) begin
                n_tests++;
                if ({b_x, b_y, b_z} !== {px[k/3], py[k/3], pz[k/3]} || b_last !== (k == 6)) begin
                    n_fail++;
                    $display("FAIL gap2_data%0d: got xyz=%h l=%b, want xyz=%h l=%b",
                             k, {b_x, b_y, b_z}, b_last, {px[k/3], py[k/3], pz[k/3]}, (k == 6));
                end
            end
            if (k < 7) tick();
        end
    endtask

    task automatic test_mid_stream();
        a_start = 1'b1; tick(); a_start = 1'b0;
        n_tests++;
        if (a_valid !== 1'b1 || a_done !== 1'b0 || {a_x, a_y, a_z} !== {px[0], py[0], pz[0]}) begin
            n_fail++;
            $display("FAIL mid_beat0: got v=%b d=%b xyz=%h, want v=1 d=0 xyz=%h",
                     a_valid, a_done, {a_x, a_y, a_z}, {px[0], py[0], pz[0]});
        end
        a_start = 1'b1; a_wr_en = 1'b1; a_wr_x = 8'd1; a_wr_y = 8'd2; a_wr_z = 8'd3;
        tick();
        a_start = 1'b0; a_wr_en = 1'b0;
        n_tests++;
        if (a_valid !== 1'b1 || a_last !== 1'b0 || a_count !== 7'd3
            || {a_x, a_y, a_z} !== {px[1], py[1], pz[1]}) begin
            n_fail++;
            $display("FAIL mid_beat1: got v=%b l=%b cnt=%0d xyz=%h, want v=1 l=0 cnt=3 xyz=%h",
                     a_valid, a_last, a_count, {a_x, a_y, a_z}, {px[1], py[1], pz[1]});
        end
        tick();
        n_tests++;
        if (a_valid !== 1'b1 || a_last !== 1'b1 || {a_x, a_y, a_z} !== {px[2], py[2], pz[2]}) begin
            n_fail++;
            $display("FAIL mid_beat2: got v=%b l=%b xyz=%h, want v=1 l=1 xyz=%h",
                     a_valid, a_last, {a_x, a_y, a_z}, {px[2], py[2], pz[2]});
        end
        tick();
        n_tests++;
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_valid !== 1'b0 || a_count !== 7'd3) begin
            n_fail++;
            $display("FAIL mid_done: got d=%b b=%b v=%b cnt=%0d, want d=1 b=0 v=0 cnt=3",
                     a_done, a_busy, a_valid, a_count);
        end
        // replay
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (a_valid !== 1'b1 || a_last !== (k == 2) || a_done !== 1'b0
                || {a_x, a_y, a_z} !== {px[k], py[k], pz[k]}) begin
                n_fail++;
                $display("FAIL replay_beat%0d: got v=%b l=%b d=%b xyz=%h, want v=1 l=%b d=0 xyz=%h",
                         k, a_valid, a_last, a_done, {a_x, a_y, a_z}, (k == 2), {px[k], py[k], pz[k]});
            end
            tick();
        end
        n_tests++;
        if (a_done !== 1'b1 || a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL replay_done: got d=%b v=%b, want d=1 v=0", a_done, a_valid);
        end
    endtask

    task automatic test_async_reset();
        int seen;
        b_start = 1'b1; tick(); b_start = 1'b0;
        tick(); tick(); tick();
        n_tests++;
        if (b_valid !== 1'b1 || {b_x, b_y, b_z} !== {px[1], py[1], pz[1]}) begin
            n_fail++;
            $display("FAIL arst_pre: got v=%b xyz=%h, want v=1 xyz=%h",
                     b_valid, {b_x, b_y, b_z}, {px[1], py[1], pz[1]});
        end
        #2 b_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({b_valid, b_last, b_busy, b_done} !== 4'b0 || b_count !== 7'd0) begin
            n_fail++;
            $display("FAIL arst_now: got v=%b l=%b b=%b d=%b cnt=%0d, want all 0",
                     b_valid, b_last, b_busy, b_done, b_count);
        end
        tick(); tick();
        b_rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (b_valid === 1'b1 || b_busy === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL arst_after: got %0d active cycles, want 0", seen);
        end
    endtask

    task automatic test_overflow_clear();
        int bad;
        a_clear = 1'b1; tick(); a_clear = 1'b0;
        n_tests++;
        if (a_count !== 7'd0 || a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_idle: got cnt=%0d d=%b, want cnt=0 d=0", a_count, a_done);
        end
        for (int i = 0; i < 64; i++) load_a(8'(i), 8'(i + 64), 8'(i + 128));
        n_tests++;
        if (a_count !== 7'd64 || a_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL full: got cnt=%0d ovf=%b, want cnt=64 ovf=0", a_count, a_ovf);
        end
        load_a(8'hEE, 8'hEE, 8'hEE);
        n_tests++;
        if (a_count !== 7'd64 || a_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf: got cnt=%0d ovf=%b, want cnt=64 ovf=1", a_count, a_ovf);
        end
        a_start = 1'b1; tick(); a_start = 1'b0;
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            if (a_valid !== 1'b1 || a_last !== (k == 63)
                || {a_x, a_y, a_z} !== {8'(k), 8'(k + 64), 8'(k + 128)}) bad++;
            tick();
        end
        n_tests++;
        if (bad != 0 || a_done !== 1'b1 || a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_stream: got %0d bad beats d=%b v=%b, want 0 bad d=1 v=0",
                     bad, a_done, a_valid);
        end
        a_clear = 1'b1; a_wr_en = 1'b1; a_wr_x = 8'd5; a_wr_y = 8'd6; a_wr_z = 8'd7;
        tick();
        a_clear = 1'b0; a_wr_en = 1'b0;
        n_tests++;
        if (a_count !== 7'd0 || a_ovf !== 1'b0 || a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_wr: got cnt=%0d ovf=%b d=%b, want cnt=0 ovf=0 d=0",
                     a_count, a_ovf, a_done);
        end
    endtask

    task automatic test_empty_start();
        a_start = 1'b1; tick(); a_start = 1'b0;
        n_tests++;
        if (a_valid !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_t1: got v=%b d=%b b=%b, want v=0 d=0 b=0", a_valid, a_done, a_busy);
        end
        tick();
        n_tests++;
        if (a_valid !== 1'b0 || a_done !== 1'b1 || a_last !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_t2: got v=%b d=%b l=%b, want v=0 d=1 l=0", a_valid, a_done, a_last);
        end
        load_a(8'd9, 8'd9, 8'd9);
        a_clear = 1'b1; a_start = 1'b1; tick();
        a_clear = 1'b0; a_start = 1'b0;
        tick();
        n_tests++;
        if (a_count !== 7'd0 || a_valid !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_start: got cnt=%0d v=%b b=%b d=%b, want cnt=0 v=0 b=0 d=0",
                     a_count, a_valid, a_busy, a_done);
        end
    endtask

    initial begin
        a_rst_n = 1'b0; a_wr_en = 1'b0; a_clear = 1'b0; a_start = 1'b0;
        a_wr_x = 8'd0; a_wr_y = 8'd0; a_wr_z = 8'd0;
        b_rst_n = 1'b0; b_wr_en = 1'b0; b_clear = 1'b0; b_start = 1'b0;
        b_wr_x = 8'd0; b_wr_y = 8'd0; b_wr_z = 8'd0;
        px[0] = 8'd10; py[0] = 8'd20; pz[0] = 8'd30;
        px[1] = 8'd40; py[1] = 8'd50; pz[1] = 8'd60;
        px[2] = 8'd70; py[2] = 8'd80; pz[2] = 8'd90;

        test_reset();
        test_stream_gap0();
        test_stream_gap2();
        test_mid_stream();
        test_async_reset();
        test_overflow_clear();
        test_empty_start();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_point_stream_tx
`default_nettype wire
